// File: rtl/npower_bus_arbiter.sv
// rtl/npower_bus_arbiter.sv - round-robin fetch/data bus arbiter with strobe watchdog
// Grants are held for the master's whole cyc tenure; stalled strobes are ended with an error pulse.
module npower_bus_arbiter #(
  parameter int AWID = 32,
  parameter int DWID = 32,
  parameter int TMO  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_cyc_i,
  input  logic              i_stb_i,
  input  logic [DWID/8-1:0] i_sel_i,
  input  logic [AWID-1:0]   i_adr_i,
  output logic              i_ack_o,
  output logic              i_err_o,
  output logic [DWID-1:0]   i_dat_o,
  input  logic              d_cyc_i,
  input  logic              d_stb_i,
  input  logic              d_we_i,
  input  logic [DWID/8-1:0] d_sel_i,
  input  logic [AWID-1:0]   d_adr_i,
  input  logic [DWID-1:0]   d_dat_i,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic [DWID-1:0]   d_dat_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [DWID/8-1:0] sel_o,
  output logic [AWID-1:0]   adr_o,
  output logic [DWID-1:0]   dat_o,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic [DWID-1:0]   dat_i,
  output logic              icaccess_o,
  output logic              maccess_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;
  localparam logic [7:0] TMO_C    = 8'(TMO);

  logic [1:0] state;
  logic       last_d;
  logic [7:0] wd_cnt;
  logic       wd_err;

  // last_d=1 means the data master held the previous tenure
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      last_d <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cyc_i && d_cyc_i)
            state <= last_d ? ST_GNT_I : ST_GNT_D;
          else if (d_cyc_i)
            state <= ST_GNT_D;
          else if (i_cyc_i)
            state <= ST_GNT_I;
        end
        ST_GNT_I: begin
          if (!i_cyc_i) begin
            state  <= ST_IDLE;
            last_d <= 1'b0;
          end
        end
        ST_GNT_D: begin
          if (!d_cyc_i) begin
            state  <= ST_IDLE;
            last_d <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Error pulse is registered so it lands exactly TMO cycles after the stall began
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt <= 8'd0;
      wd_err <= 1'b0;
    end else begin
      wd_err <= 1'b0;
      if (!stb_o || ack_i || err_i) begin
        wd_cnt <= 8'd0;
      end else if (wd_cnt + 8'd1 == TMO_C) begin
        wd_cnt <= 8'd0;
        wd_err <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    we_o    = 1'b0;
    sel_o   = '0;
    adr_o   = '0;
    dat_o   = '0;
    i_ack_o = 1'b0;
    i_err_o = 1'b0;
    i_dat_o = '0;
    d_ack_o = 1'b0;
    d_err_o = 1'b0;
    d_dat_o = '0;
    case (state)
      ST_GNT_I: begin
        cyc_o   = i_cyc_i;
        stb_o   = i_stb_i;
        sel_o   = i_sel_i;
        adr_o   = i_adr_i;
        i_ack_o = ack_i;
        i_err_o = err_i | wd_err;
        i_dat_o = dat_i;
      end
      ST_GNT_D: begin
        cyc_o   = d_cyc_i;
        stb_o   = d_stb_i;
        we_o    = d_we_i;
        sel_o   = d_sel_i;
        adr_o   = d_adr_i;
        dat_o   = d_dat_i;
        d_ack_o = ack_i;
        d_err_o = err_i | wd_err;
        d_dat_o = dat_i;
      end
      default: ;
    endcase
  end

  assign icaccess_o = (state == ST_GNT_I);
  assign maccess_o  = (state == ST_GNT_D);

endmodule

// File: tb/tb_npower_bus_arbiter.sv
// tb/tb_npower_bus_arbiter.sv - directed and randomized checks of npower_bus_arbiter
// Random phase compares against a tenure/run-length model of the arbitration rules.
module tb_npower_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          i_cyc_i, i_stb_i;
  logic [3:0]    i_sel_i;
  logic [AW-1:0] i_adr_i;
  logic          i_ack_o, i_err_o;
  logic [DW-1:0] i_dat_o;
  logic          d_cyc_i, d_stb_i, d_we_i;
  logic [3:0]    d_sel_i;
  logic [AW-1:0] d_adr_i;
  logic [DW-1:0] d_dat_i;
  logic          d_ack_o, d_err_o;
  logic [DW-1:0] d_dat_o;
  logic          cyc_o, stb_o, we_o;
  logic [3:0]    sel_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic          ack_i, err_i;
  logic [DW-1:0] dat_i;
  logic          icaccess_o, maccess_o;

  int errors = 0;
  int checks = 0;

  npower_bus_arbiter #(.AWID(AW), .DWID(DW), .TMO(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_sel_i(i_sel_i), .i_adr_i(i_adr_i),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_dat_o(i_dat_o),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_dat_o(d_dat_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
    .dat_o(dat_o), .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .icaccess_o(icaccess_o), .maccess_o(maccess_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs;
    i_cyc_i = 0; i_stb_i = 0; i_sel_i = 0; i_adr_i = 0;
    d_cyc_i = 0; d_stb_i = 0; d_we_i = 0; d_sel_i = 0; d_adr_i = 0; d_dat_i = 0;
    ack_i = 0; err_i = 0; dat_i = 0;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset;
    rst_i = 1;
    idle_inputs();
    @(negedge clk_i);
    checks++; if ({cyc_o, stb_o, icaccess_o, maccess_o} !== 4'b0000) begin errors++; $display("FAIL reset_ctl: got %b want 0000", {cyc_o, stb_o, icaccess_o, maccess_o}); end
    checks++; if ({i_ack_o, i_err_o, d_ack_o, d_err_o} !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %b want 0000", {i_ack_o, i_err_o, d_ack_o, d_err_o}); end
    tick();
    rst_i = 0;
    tick();
  endtask

  task automatic test_single_data;
    d_cyc_i = 1; d_stb_i = 1; d_we_i = 0; d_adr_i = 32'h0000_1000; d_sel_i = 4'hf;
    @(negedge clk_i);
    checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL single_c0_cyc: got %b want 0", cyc_o); end
    tick();
    @(negedge clk_i);
    checks++; if ({cyc_o, maccess_o, d_ack_o} !== 3'b110) begin errors++; $display("FAIL single_c1: got %b want 110", {cyc_o, maccess_o, d_ack_o}); end
    checks++; if (adr_o !== 32'h0000_1000) begin errors++; $display("FAIL single_adr: got %h want 00001000", adr_o); end
    tick();
    ack_i = 1; dat_i = 32'hcafe_f00d;
    @(negedge clk_i);
    checks++; if ({cyc_o, d_ack_o, i_ack_o} !== 3'b110) begin errors++; $display("FAIL single_c2: got %b want 110", {cyc_o, d_ack_o, i_ack_o}); end
    checks++; if (d_dat_o !== 32'hcafe_f00d) begin errors++; $display("FAIL single_dat: got %h want cafef00d", d_dat_o); end
    checks++; if (i_dat_o !== 32'h0) begin errors++; $display("FAIL single_idat: got %h want 0", i_dat_o); end
    tick();
    d_cyc_i = 0; d_stb_i = 0; ack_i = 0;
    @(negedge clk_i);
    checks++; if ({cyc_o, maccess_o} !== 2'b01) begin errors++; $display("FAIL single_drop: got %b want 01", {cyc_o, maccess_o}); end
    tick();
    @(negedge clk_i);
    checks++; if (maccess_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", maccess_o); end
    settle();
  endtask

  task automatic test_simultaneous;
    test_reset();
    i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1;
    tick();
    @(negedge clk_i);
    checks++; if ({icaccess_o, maccess_o} !== 2'b01) begin errors++; $display("FAIL simul_first: got %b want 01", {icaccess_o, maccess_o}); end
    tick();
    ack_i = 1;
    @(negedge clk_i);
    checks++; if ({d_ack_o, i_ack_o} !== 2'b10) begin errors++; $display("FAIL simul_ack: got %b want 10", {d_ack_o, i_ack_o}); end
    tick();
    ack_i = 0; d_cyc_i = 0; d_stb_i = 0;
    tick();
    d_cyc_i = 1; d_stb_i = 1;
    @(negedge clk_i);
    checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL simul_dead: got %b want 0", cyc_o); end
    tick();
    @(negedge clk_i);
    checks++; if ({cyc_o, icaccess_o, maccess_o} !== 3'b110) begin errors++; $display("FAIL simul_last_d: got %b want 110", {cyc_o, icaccess_o, maccess_o}); end
    settle();
  endtask

  task automatic test_line_fill;
    logic [31:0] d;
    i_cyc_i = 1; i_stb_i = 1; i_sel_i = 4'hf; i_adr_i = 32'h0000_4000;
    tick();
    for (int b = 0; b < 8; b++) begin
      i_adr_i = 32'h0000_4000 + 32'(b * 4);
      ack_i = 1;
      d = $urandom;
      dat_i = d;
      if (b >= 2) begin d_cyc_i = 1; d_stb_i = 1; d_adr_i = 32'h0000_9000; end
      @(negedge clk_i);
      checks++; if (adr_o !== i_adr_i) begin errors++; $display("FAIL fill_adr beat %0d: got %h want %h", b, adr_o, i_adr_i); end
      checks++; if ({icaccess_o, i_ack_o, d_ack_o} !== 3'b110) begin errors++; $display("FAIL fill_ack beat %0d: got %b want 110", b, {icaccess_o, i_ack_o, d_ack_o}); end
      checks++; if (i_dat_o !== d) begin errors++; $display("FAIL fill_dat beat %0d: got %h want %h", b, i_dat_o, d); end
      tick();
    end
    ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
    tick();
    @(negedge clk_i);
    checks++; if ({cyc_o, maccess_o} !== 2'b00) begin errors++; $display("FAIL fill_dead: got %b want 00", {cyc_o, maccess_o}); end
    tick();
    @(negedge clk_i);
    checks++; if ({cyc_o, maccess_o, adr_o} !== {2'b11, 32'h0000_9000}) begin errors++; $display("FAIL fill_handoff: got %b %h want 11 00009000", {cyc_o, maccess_o}, adr_o); end
    settle();
  endtask

  task automatic test_err_passthrough;
    i_cyc_i = 1; i_stb_i = 1;
    tick();
    err_i = 1;
    @(negedge clk_i);
    checks++; if ({i_err_o, i_ack_o, d_err_o} !== 3'b100) begin errors++; $display("FAIL err_pass: got %b want 100", {i_err_o, i_ack_o, d_err_o}); end
    tick();
    ack_i = 1; err_i = 1;
    @(negedge clk_i);
    checks++; if ({i_ack_o, i_err_o, d_ack_o, d_err_o} !== 4'b1100) begin errors++; $display("FAIL err_both: got %b want 1100", {i_ack_o, i_err_o, d_ack_o, d_err_o}); end
    settle();
  endtask

  task automatic test_watchdog;
    d_cyc_i = 1; d_stb_i = 1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      checks++; if ({d_err_o, i_err_o} !== {(c == 1 + TMO) || (c == 1 + 2 * TMO), 1'b0}) begin errors++; $display("FAIL watchdog cycle %0d: got %b want %b", c, {d_err_o, i_err_o}, {(c == 1 + TMO) || (c == 1 + 2 * TMO), 1'b0}); end
      tick();
    end
    settle();
  endtask

  task automatic test_reset_mid_burst;
    i_cyc_i = 1; i_stb_i = 1;
    tick();
    d_cyc_i = 1; d_stb_i = 1;
    ack_i = 1;
    tick();
    tick();
    rst_i = 1;
    #1;
    checks++; if ({cyc_o, stb_o, icaccess_o, i_ack_o} !== 4'b0000) begin errors++; $display("FAIL rst_mid: got %b want 0000", {cyc_o, stb_o, icaccess_o, i_ack_o}); end
    @(negedge clk_i);
    rst_i = 0;
    tick();
    @(negedge clk_i);
    checks++; if ({icaccess_o, maccess_o} !== 2'b01) begin errors++; $display("FAIL rst_regrant: got %b want 01", {icaccess_o, maccess_o}); end
    settle();
  endtask

  task automatic test_random;
    int owner, last_owner, run;
    logic gi, gd, wd, e_stb;
    logic [4:0] e_ctl;
    logic [AW+DW+3:0] e_bus;
    logic [3:0] e_rsp;
    logic [2*DW-1:0] e_dat;
    test_reset();
    owner = 0; last_owner = 1; run = 0;
    for (int c = 0; c < 400; c++) begin
      if (i_cyc_i) i_cyc_i = ($urandom % 6) != 0; else i_cyc_i = ($urandom % 4) == 0;
      if (d_cyc_i) d_cyc_i = ($urandom % 6) != 0; else d_cyc_i = ($urandom % 4) == 0;
      i_stb_i = i_cyc_i & (($urandom % 4) != 0);
      d_stb_i = d_cyc_i & (($urandom % 4) != 0);
      d_we_i = 1'($urandom);
      i_sel_i = 4'($urandom); d_sel_i = 4'($urandom);
      i_adr_i = $urandom; d_adr_i = $urandom; d_dat_i = $urandom; dat_i = $urandom;
      ack_i = ($urandom % 3) == 0;
      err_i = ($urandom % 8) == 0;
      gi = (owner == 1);
      gd = (owner == 2);
      wd = (owner != 0) && (run > 0) && (run % TMO == 0);
      e_stb = (gi & i_stb_i) | (gd & d_stb_i);
      e_ctl = {(gi & i_cyc_i) | (gd & d_cyc_i), e_stb, gd & d_we_i, gi, gd};
      e_bus = gi ? {i_sel_i, i_adr_i, 32'h0} : gd ? {d_sel_i, d_adr_i, d_dat_i} : '0;
      e_rsp = {gi & ack_i, gi & (err_i | wd), gd & ack_i, gd & (err_i | wd)};
      e_dat = {gi ? dat_i : 32'h0, gd ? dat_i : 32'h0};
      @(negedge clk_i);
      checks++; if ({cyc_o, stb_o, we_o, icaccess_o, maccess_o} !== e_ctl) begin errors++; $display("FAIL rand_ctl cycle %0d: got %b want %b", c, {cyc_o, stb_o, we_o, icaccess_o, maccess_o}, e_ctl); end
      checks++; if ({sel_o, adr_o, dat_o} !== e_bus) begin errors++; $display("FAIL rand_bus cycle %0d: got %h want %h", c, {sel_o, adr_o, dat_o}, e_bus); end
      checks++; if ({i_ack_o, i_err_o, d_ack_o, d_err_o} !== e_rsp) begin errors++; $display("FAIL rand_rsp cycle %0d: got %b want %b", c, {i_ack_o, i_err_o, d_ack_o, d_err_o}, e_rsp); end
      checks++; if ({i_dat_o, d_dat_o} !== e_dat) begin errors++; $display("FAIL rand_dat cycle %0d: got %h want %h", c, {i_dat_o, d_dat_o}, e_dat); end
      if (e_stb && !ack_i && !err_i) run++; else run = 0;
      if (owner == 0) begin
        if (i_cyc_i && d_cyc_i) owner = (last_owner == 1) ? 2 : 1;
        else if (d_cyc_i) owner = 2;
        else if (i_cyc_i) owner = 1;
      end else if ((owner == 1 && !i_cyc_i) || (owner == 2 && !d_cyc_i)) begin
        last_owner = owner;
        owner = 0;
      end
      tick();
    end
    settle();
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    test_single_data();
    test_simultaneous();
    test_line_fill();
    test_err_passthrough();
    test_watchdog();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npower_bus_arbiter.md
# npower_bus_arbiter

Two-master bus arbiter for the nPower core. It shares the single external bus (cyc/stb/ack, classic-cycle handshake) between the instruction-cache line-fill engine and the data memory stage. Grants are round-robin when both masters request and are held for a master's whole cyc tenure, including multi-beat cache-line fills. A bus watchdog terminates stalled transfers with an error so neither pipeline stage hangs.

## Interface
Parameters:
- AWID, 32, address width
- DWID, 32, data width (32, 64 or 128; matches CPU_B32/B64/B128 builds)
- TMO, 255, cycles a strobe may wait for ack_i/err_i before the watchdog fires (1..255)

Ports. One clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- i_cyc_i, i_stb_i  in  1  instruction-fetch master request and strobe
- i_sel_i  in  DWID/8  fetch byte selects
- i_adr_i  in  AWID  fetch address
- i_ack_o, i_err_o  out  1  fetch-master acknowledge and error
- i_dat_o  out  DWID  fetch read data
- d_cyc_i, d_stb_i, d_we_i  in  1  data master request, strobe and write enable
- d_sel_i  in  DWID/8  data byte selects
- d_adr_i  in  AWID  data address
- d_dat_i  in  DWID  store data
- d_ack_o, d_err_o  out  1  data-master acknowledge and error
- d_dat_o  out  DWID  load data
- cyc_o, stb_o, we_o  out  1  bus cycle, strobe and write enable
- sel_o  out  DWID/8  bus byte selects
- adr_o  out  AWID  bus address
- dat_o  out  DWID  bus write data
- ack_i, err_i  in  1  bus acknowledge and error
- dat_i  in  DWID  bus read data
- icaccess_o, maccess_o  out  1  fetch grant and data grant (registered state)

## Operation
- States: IDLE, GNT_I, GNT_D. State and the `last` flag are registered. Reset forces IDLE with last=I.
- IDLE:
  - Both cyc inputs high: grant the master that was not served last (D after reset).
  - Only one cyc input high: grant that master.
  - Neither high: stay in IDLE.
- GNT_x:
  - Bus outputs are a combinational mux of master x's cyc/stb/we/sel/adr/dat.
  - ack_i, err_i and dat_i route only to master x. The other master's ack/err is 0; its dat_o is 0.
  - When x_cyc_i goes low, go to IDLE on the next edge and set last=x.
  - There is no preemption. A fetch line fill (8/4/2 beats, DWID 32/64/128) holds the bus until the fetch engine drops i_cyc_i.
- IDLE outputs: cyc_o, stb_o, we_o, sel_o, adr_o and dat_o are 0. All ack/err/dat outputs are 0.
- Watchdog:
  - An 8-bit counter clears when stb_o=0 or on ack_i|err_i.
  - It increments each cycle that stb_o=1 with no ack_i/err_i.
  - When it reaches TMO, x_err_o pulses for exactly one cycle and the counter clears.
  - The state stays GNT_x; the master must drop cyc.
- ack_i and err_i asserted together: ack and err both pass through to the granted master.
- icaccess_o=(state==GNT_I) and maccess_o=(state==GNT_D). They are never both 1.

## Timing
- Grant latency: cyc request sampled in IDLE at edge N, so cyc_o is high in cycle N+1. Minimum 1 cycle.
- Release: x_cyc_i low in cycle M gives IDLE in M+1. The next grant shows cyc_o in M+2, giving one dead cycle between tenures.
- ack/err/dat pass-through is zero-latency (combinational) while granted.
- Watchdog: with stb_o high from cycle S and no ack, x_err_o is high in cycle S+TMO.
- Asynchronous reset mid-transfer: state goes to IDLE immediately, all outputs go to 0, the counter clears and last=I. Any in-flight bus cycle is abandoned.
- A request that drops before it is granted is ignored with no residual grant.

## Test plan
- Single data request: d_cyc/stb high at cycle 0, ack_i at cycle 2 -> cyc_o high cycles 1-2, d_ack_o high cycle 2, d_dat_o=dat_i, maccess_o=1.
- Simultaneous request after reset: both cyc high at cycle 0 -> data granted first. Data drops cyc after its ack -> fetch cyc_o asserts 2 cycles after the drop; last=D.
- Line fill with contention (DWID=32): fetch granted, 8 acked beats while d_cyc_i rises at beat 2 -> adr_o tracks i_adr_i for all 8 beats, d_ack_o stays 0. Data is granted 2 cycles after i_cyc_i falls.
- Watchdog (TMO=4): data strobe with no ack -> d_err_o high exactly in cycle 4 after the strobe starts, for one cycle. The counter restarts, giving a second pulse at cycle 8 if the master holds stb.
- Error pass-through: err_i during a fetch beat -> i_err_o=1 the same cycle, d_err_o=0.
- Reset mid-burst: rst_i at fetch beat 3 -> cyc_o/stb_o/icaccess_o low within the reset cycle. After release, a pending data request is granted first.
